main_memory_responder: RTL
==========================

Name: main_memory_responder

Overview:
Memory-side responder for the cache controller's main-memory strobe interface (MStrobe/MRW). It accepts one read or write request per strobe and models a fixed multi-cycle main-memory access using an internal word array. It returns a one-cycle ready pulse and, for reads, registered data. This block is the counterpart the cache controller waits on. Its LATENCY must match the count the controller loads into its latency counter.

Parameters:
ADDR_W, 6, address width; array depth = 2**ADDR_W words
DATA_W, 32, word width
LATENCY, 4, cycles from strobe sample to ready pulse; legal range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
MStrobe  in  1  request strobe, one cycle per request
MRW  in  1  1 = write, 0 = read (same encoding as controller's MRW)
MAddr  in  ADDR_W  word address, sampled with MStrobe
MDataIn  in  DATA_W  write data, sampled with MStrobe
MDataOut  out  DATA_W  registered read data
MRdy  out  1  one-cycle completion pulse
MBusy  out  1  request in flight, new strobes not accepted
MOvr  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset: state IDLE, counter 0, MRdy=0, MBusy=0, MOvr=0, MDataOut=0, latched request cleared. Array contents are not altered by reset.
- States:
  - IDLE: if MStrobe=1, latch MRW, MAddr and MDataIn. If LATENCY=1, go to RESP; otherwise load cnt=LATENCY-2 and go to WAIT.
  - WAIT: if cnt=0, go to RESP; else cnt=cnt-1.
  - RESP: MRdy=1. If MStrobe=1, accept exactly as in IDLE (back-to-back); else go to IDLE.
- Timing: a strobe sampled in cycle k produces MRdy=1 in cycle k+LATENCY only.
- MBusy=1 exactly in WAIT, i.e. cycles k+1..k+LATENCY-1. MBusy is 0 in IDLE and RESP.
- Access commit: happens on the clock edge that enters RESP.
  - Write: array[addr] <= latched data; MDataOut unchanged.
  - Read: MDataOut <= array[addr]. It is valid throughout the MRdy cycle and held until the next read commits.
- Read-after-write to the same address, back-to-back, returns the new data, because the write commits before the read is accepted.
- MStrobe=1 while in WAIT: request ignored, MOvr<=1. The in-flight request is unaffected. MOvr clears only on reset.
- MRW, MAddr and MDataIn are don't-care when not sampled.
- Reset mid-operation: the in-flight request is aborted and no write commits (including when reset is asserted in the would-be commit cycle). No MRdy is emitted, and the outputs take their reset values on the next cycle.
- Counter width is 4 bits; the counter never wraps because LATENCY ≤ 15.
- The next state is a pure function of state, cnt and MStrobe. No combinational path exists from inputs to MRdy or MBusy.

Test Plan:
- Reset check: hold reset 2 cycles with MStrobe=1 -> MRdy=0, MBusy=0, MOvr=0, MDataOut=0. After release, no MRdy without a strobe.
- Write then read, LATENCY=4:
  - Write 0xDEADBEEF to addr 5, strobe in cycle 0 -> MBusy=1 in cycles 1-3, MRdy=1 only in cycle 4, MDataOut stays 0.
  - Read addr 5 strobed in cycle 6 -> MRdy in cycle 10 with MDataOut=0xDEADBEEF.
- Back-to-back: strobe a write of 0x12345678 to addr 9, then strobe a read of addr 9 in that write's MRdy cycle -> second MRdy exactly 4 cycles later with MDataOut=0x12345678, MOvr=0.
- Overrun: strobe a read of addr 3 in cycle 0, strobe again in cycle 2 -> MOvr=1 from cycle 3 onward, a single MRdy in cycle 4 with addr 3 data, and no second MRdy.
- Reset mid-write:
  - Write 0xAAAA0000 to addr 7 (which holds 0x11) and assert reset in cycle 2 -> no MRdy.
  - A subsequent read of addr 7 returns 0x11.
- LATENCY=1 instance: strobe in cycle 0 -> MRdy in cycle 1, and MBusy is never 1.
- LATENCY=1 continuous strobes every cycle -> MRdy every cycle from cycle 1, MOvr=0.

Source files
------------

// File: rtl/main_memory_responder.sv
// ---------------------------------------------------------------------------
// main_memory_responder
//
// Memory-side responder for the cache controller's MStrobe/MRW interface.
// Each accepted strobe models a fixed LATENCY-cycle main-memory access into an
// internal word array. Completion is signalled by a one-cycle MRdy pulse. A
// read also returns registered data on MDataOut.
//
// Parameters:
//   ADDR_W   word address width; the array holds 2**ADDR_W words
//   DATA_W   word width
//   LATENCY  cycles from strobe sample to MRdy pulse (1..15); must match the
//            controller's latency counter load value
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous active-high reset
//   MStrobe   request strobe, one cycle per request
//   MRW       1 = write, 0 = read
//   MAddr     word address, sampled with MStrobe
//   MDataIn   write data, sampled with MStrobe
//   MDataOut  registered read data, held until the next read commits
//   MRdy      one-cycle completion pulse
//   MBusy     request in flight; strobes are not accepted
//   MOvr      sticky flag: a strobe arrived while busy (cleared by reset only)
// ---------------------------------------------------------------------------
module main_memory_responder #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MRdy,
    output logic              MBusy,
    output logic              MOvr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // WAIT runs LATENCY-1 cycles: loaded with LATENCY-2 and left on cnt==0.
    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       LAT1     = (LATENCY == 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              accept;
    logic              commit;
    logic              c_rw;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        accept  = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MStrobe) accept = 1'b1;
            end
            S_WAIT: begin
                // The in-flight request keeps going; the extra strobe is only flagged.
                if (MStrobe) ovr_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (MStrobe) accept = 1'b1;
                else         state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            rw_d   = MRW;
            addr_d = MAddr;
            data_d = MDataIn;
            if (LAT1) begin
                state_d = S_RESP;
                commit  = 1'b1;
            end else begin
                state_d = S_WAIT;
                cnt_d   = CNT_LOAD;
            end
        end
    end

    // With LATENCY=1 the request commits on the same edge that samples it, so
    // the access must use the live inputs instead of the latched copy.
    always_comb begin
        c_rw   = rw_q;
        c_addr = addr_q;
        c_data = data_q;
        if (accept) begin
            c_rw   = MRW;
            c_addr = MAddr;
            c_data = MDataIn;
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (commit && !c_rw) dout_d = mem_q[c_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            ovr_q   <= ovr_d;
        end
    end

    // Array is not cleared by reset, but a reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && c_rw) mem_q[c_addr] <= c_data;
    end

    assign MDataOut = dout_q;
    assign MRdy     = (state_q == S_RESP);
    assign MBusy    = (state_q == S_WAIT);
    assign MOvr     = ovr_q;

endmodule
